// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS system control coprocessor (SR, Cause, EPC, PRId, BadVAddr) at the M stage.
// Defining CP0_TIMER_EN adds the Count/Compare timer, whose TI flag is ORed into line TIMER_LINE.
module cp0_ctrl #(
    parameter int unsigned HW_INT_W   = 6,
    parameter logic [31:0] PRID       = 32'h0000_7700,
    parameter int unsigned TIMER_LINE = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [4:0]          CP0Add,
    input  logic [31:0]         CP0In,
    output logic [31:0]         CP0Out,
    input  logic [31:0]         VPC,
    input  logic                BDIn,
    input  logic [4:0]          ExcCodeIn,
    input  logic [31:0]         BadVAddrIn,
    input  logic [HW_INT_W-1:0] HWInt,
    input  logic                EXLClr,
    output logic [31:0]         EPCOut,
    output logic                Req
);

    localparam logic [4:0] IDX_BADVADDR = 5'd8;
    localparam logic [4:0] IDX_SR       = 5'd12;
    localparam logic [4:0] IDX_CAUSE    = 5'd13;
    localparam logic [4:0] IDX_EPC      = 5'd14;
    localparam logic [4:0] IDX_PRID     = 5'd15;

    logic [HW_INT_W-1:0] im_q, im_d;
    logic [HW_INT_W-1:0] ip_q, ip_d;
    logic                exl_q, exl_d;
    logic                ie_q, ie_d;
    logic                bd_q, bd_d;
    logic [4:0]          exccode_q, exccode_d;
    logic [31:0]         epc_q, epc_d;
    logic [31:0]         badvaddr_q, badvaddr_d;

    logic                ti_s;
    logic [HW_INT_W-1:0] timer_vec_s;
    logic                int_pend_s;
    logic                exc_pend_s;
    logic                req_s;
    logic                mtc0_s;
    logic                addr_exc_s;
    logic [31:0]         sr_s;
    logic [31:0]         cause_s;
    logic [31:0]         rdata_s;

`ifdef CP0_TIMER_EN
    localparam logic [4:0] IDX_COUNT   = 5'd9;
    localparam logic [4:0] IDX_COMPARE = 5'd11;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    assign ti_s = ti_q;
`else
    assign ti_s = 1'b0;
`endif

    // Place the timer flag on its interrupt line; all other lines stay clear.
    always_comb begin
        timer_vec_s             = '0;
        timer_vec_s[TIMER_LINE] = ti_s;
    end

    // Interrupts look at the live lines, not the registered IP view.
    assign int_pend_s = (|((HWInt | timer_vec_s) & im_q)) & ie_q & ~exl_q;
    assign exc_pend_s = (ExcCodeIn != 5'd0) & ~exl_q;
    assign req_s      = int_pend_s | exc_pend_s;
    assign mtc0_s     = en & ~req_s;
    assign addr_exc_s = (ExcCodeIn == 5'd4) | (ExcCodeIn == 5'd5);

    assign Req    = req_s;
    assign EPCOut = epc_q;
    assign CP0Out = rdata_s;

    // Next-state for SR, Cause, EPC and BadVAddr; an exception entry discards the mtc0.
    always_comb begin
        im_d       = im_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ip_d       = HWInt | timer_vec_s;

        if (req_s) begin
            bd_d      = BDIn;
            exccode_d = int_pend_s ? 5'd0 : ExcCodeIn;
            epc_d     = BDIn ? (VPC - 32'd4) : VPC;
            if (!int_pend_s && addr_exc_s) begin
                badvaddr_d = BadVAddrIn;
            end else begin
                badvaddr_d = badvaddr_q;
            end
        end else if (mtc0_s) begin
            case (CP0Add)
                IDX_SR: begin
                    im_d = CP0In[10 +: HW_INT_W];
                    ie_d = CP0In[0];
                end
                IDX_EPC: begin
                    epc_d = CP0In;
                end
                default: begin
                    im_d  = im_q;
                    epc_d = epc_q;
                end
            endcase
        end else begin
            im_d = im_q;
        end

        if (req_s) begin
            exl_d = 1'b1;
        end else if (mtc0_s && (CP0Add == IDX_SR)) begin
            exl_d = CP0In[1];
        end else if (EXLClr) begin
            exl_d = 1'b0;
        end else begin
            exl_d = exl_q;
        end
    end

`ifdef CP0_TIMER_EN
    // Free-running Count with sticky TI; a Compare write clears TI even on a same-cycle match.
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        if (count_q == compare_q) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
        if (mtc0_s && (CP0Add == IDX_COUNT)) begin
            count_d = CP0In;
        end else begin
            count_d = count_q + 32'd1;
        end
        if (mtc0_s && (CP0Add == IDX_COMPARE)) begin
            compare_d = CP0In;
            ti_d      = 1'b0;
        end else begin
            compare_d = compare_q;
        end
    end
`endif

    // Read mux; unimplemented bits and unmapped indices return zero.
    always_comb begin
        sr_s                     = 32'd0;
        sr_s[10 +: HW_INT_W]     = im_q;
        sr_s[1]                  = exl_q;
        sr_s[0]                  = ie_q;
        cause_s                  = 32'd0;
        cause_s[31]              = bd_q;
        cause_s[30]              = ti_s;
        cause_s[10 +: HW_INT_W]  = ip_q;
        cause_s[6:2]             = exccode_q;
        case (CP0Add)
            IDX_BADVADDR: rdata_s = badvaddr_q;
            IDX_SR:       rdata_s = sr_s;
            IDX_CAUSE:    rdata_s = cause_s;
            IDX_EPC:      rdata_s = epc_q;
            IDX_PRID:     rdata_s = PRID;
`ifdef CP0_TIMER_EN
            IDX_COUNT:    rdata_s = count_q;
            IDX_COMPARE:  rdata_s = compare_q;
`endif
            default:      rdata_s = 32'd0;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            ip_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
`ifdef CP0_TIMER_EN
            count_q    <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            ti_q       <= 1'b0;
`endif
        end else begin
            im_q       <= im_d;
            ip_q       <= ip_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
`ifdef CP0_TIMER_EN
            count_q    <= count_d;
            compare_q  <= compare_d;
            ti_q       <= ti_d;
`endif
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: a vector table on a 6-line instance plus hand sequences
// for a 2-line instance and, when CP0_TIMER_EN is defined, the Count/Compare timer.
module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  add;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] bva;
    logic [5:0]  hw;
    logic        eclr;
    logic [31:0] epc;
    logic        req;

    logic        en1;
    logic [4:0]  add1;
    logic [31:0] din1;
    logic [31:0] dout1;
    logic [1:0]  hw1;
    logic [31:0] epc1;
    logic        req1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_ctrl #(.HW_INT_W(6), .PRID(32'h0000_7700), .TIMER_LINE(5)) dut (
        .clk(clk), .reset(reset), .en(en), .CP0Add(add), .CP0In(din), .CP0Out(dout),
        .VPC(vpc), .BDIn(bd), .ExcCodeIn(exc), .BadVAddrIn(bva), .HWInt(hw),
        .EXLClr(eclr), .EPCOut(epc), .Req(req)
    );

    cp0_ctrl #(.HW_INT_W(2), .PRID(32'h0000_7700), .TIMER_LINE(1)) dut2 (
        .clk(clk), .reset(reset), .en(en1), .CP0Add(add1), .CP0In(din1), .CP0Out(dout1),
        .VPC(32'd0), .BDIn(1'b0), .ExcCodeIn(5'd0), .BadVAddrIn(32'd0), .HWInt(hw1),
        .EXLClr(1'b0), .EPCOut(epc1), .Req(req1)
    );

    typedef struct packed {
        logic        en;
        logic [4:0]  add;
        logic [31:0] din;
        logic [5:0]  hw;
        logic [4:0]  exc;
        logic [31:0] vpc;
        logic        bd;
        logic [31:0] bva;
        logic        eclr;
        logic        req;
        logic [31:0] out;
        logic [31:0] epc;
    } vec_t;

    localparam int NV = 25;
    vec_t v [NV];

    function automatic vec_t mk(input logic e, input logic [4:0] a, input logic [31:0] d,
                                input logic [5:0] h, input logic [4:0] x, input logic [31:0] pc,
                                input logic b, input logic [31:0] bv, input logic c,
                                input logic r, input logic [31:0] o, input logic [31:0] ep);
        vec_t t;
        t.en = e; t.add = a; t.din = d; t.hw = h; t.exc = x; t.vpc = pc; t.bd = b;
        t.bva = bv; t.eclr = c; t.req = r; t.out = o; t.epc = ep;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %08h expected %08h", name, idx, act, exp);
        end
    endtask

    task automatic idle_main();
        en = 1'b0; add = 5'd0; din = 32'd0; vpc = 32'd0; bd = 1'b0;
        exc = 5'd0; bva = 32'd0; hw = 6'd0; eclr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //          en    add    din            hw     exc    vpc            bd    bva            eclr  req   out            epc
        v[0]  = mk(1'b0, 5'd12, 32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 32'h0);
        v[1]  = mk(1'b1, 5'd12, 32'h0000_0401, 6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 32'h0);
        v[2]  = mk(1'b0, 5'd12, 32'h0,         6'd1,  5'd0,  32'h0000_3010, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0401, 32'h0);
        v[3]  = mk(1'b0, 5'd13, 32'h0,         6'd1,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0400, 32'h0000_3010);
        v[4]  = mk(1'b0, 5'd12, 32'h0,         6'd1,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0403, 32'h0000_3010);
        v[5]  = mk(1'b1, 5'd12, 32'h0000_0400, 6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0403, 32'h0000_3010);
        v[6]  = mk(1'b0, 5'd12, 32'h0,         6'd0,  5'd4,  32'h0000_3008, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_3010);
        v[7]  = mk(1'b0, 5'd13, 32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0010, 32'h0000_3004);
        v[8]  = mk(1'b0, 5'd8,  32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0003, 32'h0000_3004);
        v[9]  = mk(1'b1, 5'd12, 32'h0000_0401, 6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0402, 32'h0000_3004);
        v[10] = mk(1'b0, 5'd8,  32'h0,         6'd1,  5'd10, 32'h0000_3020, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_3004);
        v[11] = mk(1'b0, 5'd13, 32'h0,         6'd1,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0400, 32'h0000_3020);
        v[12] = mk(1'b0, 5'd8,  32'h0,         6'd1,  5'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0003, 32'h0000_3020);
        v[13] = mk(1'b0, 5'd12, 32'h0,         6'd1,  5'd0,  32'h0000_3030, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0401, 32'h0000_3020);
        v[14] = mk(1'b0, 5'd12, 32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0403, 32'h0000_3030);
        v[15] = mk(1'b1, 5'd14, 32'h0000_4000, 6'd0,  5'd8,  32'h0000_3040, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_3030, 32'h0000_3030);
        v[16] = mk(1'b0, 5'd14, 32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3040, 32'h0000_3040);
        v[17] = mk(1'b1, 5'd13, 32'hFFFF_FFFF, 6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0020, 32'h0000_3040);
        v[18] = mk(1'b0, 5'd13, 32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0020, 32'h0000_3040);
        v[19] = mk(1'b0, 5'd15, 32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_7700, 32'h0000_3040);
        v[20] = mk(1'b1, 5'd14, 32'h0000_4000, 6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_3040, 32'h0000_3040);
        v[21] = mk(1'b0, 5'd14, 32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_4000, 32'h0000_4000);
        v[22] = mk(1'b1, 5'd12, 32'h0000_0402, 6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0401, 32'h0000_4000);
        v[23] = mk(1'b0, 5'd12, 32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0402, 32'h0000_4000);
        v[24] = mk(1'b0, 5'd3,  32'h0,         6'd0,  5'd0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 32'h0000_4000);

        idle_main();
        en1 = 1'b0; add1 = 5'd0; din1 = 32'd0; hw1 = 2'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            en = v[i].en; add = v[i].add; din = v[i].din; hw = v[i].hw; exc = v[i].exc;
            vpc = v[i].vpc; bd = v[i].bd; bva = v[i].bva; eclr = v[i].eclr;
            #1;
            chk("req", i, {31'd0, req}, {31'd0, v[i].req});
            chk("rd",  i, dout, v[i].out);
            chk("epc", i, epc, v[i].epc);
            tick();
        end
        idle_main();

        // Two-line instance: IM and IP bits above line 1 stay zero.
        en1 = 1'b1; add1 = 5'd12; din1 = 32'h0000_FC01; hw1 = 2'b11;
        #1;
        chk("w2_req_pre", 0, {31'd0, req1}, 32'd0);
        tick();
        en1 = 1'b0; add1 = 5'd12;
        #1;
        chk("w2_req", 1, {31'd0, req1}, 32'd1);
        chk("w2_sr", 1, dout1, 32'h0000_0C01);
        tick();
        add1 = 5'd13;
        #1;
        chk("w2_cause", 2, dout1, 32'h0000_0C00);
        chk("w2_req_exl", 2, {31'd0, req1}, 32'd0);
        chk("w2_epc", 2, epc1, 32'd0);
        hw1 = 2'b00;

`ifdef CP0_TIMER_EN
        en = 1'b1; add = 5'd12; din = 32'h0000_8001;
        tick();
        add = 5'd9; din = 32'd0;
        tick();
        add = 5'd11; din = 32'd5;
        tick();
        en = 1'b0; add = 5'd9;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk("t_count", k, dout, 32'(k));
            chk("t_req_lo", k, {31'd0, req}, 32'd0);
            tick();
        end
        add = 5'd13; vpc = 32'h0000_5000;
        #1;
        chk("t_req_hi", 0, {31'd0, req}, 32'd1);
        chk("t_cause_ti", 0, dout, 32'h4000_0020);
        tick();
        vpc = 32'd0;
        en = 1'b1; add = 5'd11; din = 32'd100;
        #1;
        chk("t_epc", 0, epc, 32'h0000_5000);
        tick();
        en = 1'b0; add = 5'd13;
        #1;
        chk("t_cause_clr", 0, dout, 32'h0000_8000);
        tick();
        en = 1'b1; add = 5'd9; din = 32'hFFFF_FFFF;
        tick();
        en = 1'b0;
        #1;
        chk("t_wrap_max", 0, dout, 32'hFFFF_FFFF);
        tick();
        #1;
        chk("t_wrap_zero", 0, dout, 32'd0);
        tick();
        idle_main();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
Parametrised system control coprocessor for the pipelined MIPS core. It is the next generation of the single-configuration CP0, and it adds:
- a configurable hardware interrupt width;
- BadVAddr capture for address exceptions;
- a read-only PRId register;
- write-field masking;
- an optional Count/Compare timer interrupt.

It sits at the M stage, takes exception/interrupt decisions, and supplies EPC to the PC-select logic.

Parameters:
HW_INT_W, 6, number of external interrupt lines (1..6), mapped to IP/IM bits [10+HW_INT_W-1:10].
PRID, 32'h0000_7700, constant returned on reads of register 15.
TIMER_LINE, 5, interrupt line index (0..HW_INT_W-1) into which the timer interrupt is ORed (timer build only).

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
en  in  1  mtc0 write enable.
CP0Add  in  5  register index for read and write.
CP0In  in  32  mtc0 write data.
CP0Out  out  32  combinational read data for CP0Add.
VPC  in  32  victim PC of the M-stage instruction.
BDIn  in  1  victim is in a delay slot.
ExcCodeIn  in  5  exception code from the pipeline; 0 = none.
BadVAddrIn  in  32  faulting address for AdEL/AdES.
HWInt  in  HW_INT_W  external interrupt lines, level-sensitive.
EXLClr  in  1  eret: clear EXL.
EPCOut  out  32  current EPC value.
Req  out  1  combinational request to redirect to the handler and flush.

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], TI[30], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): constant PRID.
  - BadVAddr (8): 32 bits.
  - Count (9) and Compare (11): timer build only.
  - Any other index reads 0.
- IM/IP bits at or above index HW_INT_W are tied 0 and read 0.
- Reset (sync): SR, Cause, EPC, BadVAddr, Count = 0; Compare = 32'hFFFF_FFFF. Req and EPCOut are therefore 0 the cycle after reset. Reset overrides every other event in that cycle.
- IP register: IP <= HWInt (plus TI on TIMER_LINE) every non-reset cycle. IP is a one-cycle registered view only and is not used by Req.
- Interrupt pending: int_pend = |((HWInt | timer_vec) & IM) & IE & !EXL.
  - Uses the live HWInt, not the IP register.
  - timer_vec has TI at bit TIMER_LINE and is 0 in the non-timer build.
- Exception pending: exc_pend = (ExcCodeIn != 0) & !EXL.
- Req = int_pend | exc_pend, combinational, zero latency.
- When Req = 1, on the next posedge:
  - ExcCode <= int_pend ? 0 : ExcCodeIn. Interrupts have priority over a simultaneous exception.
  - BD <= BDIn.
  - EPC <= BDIn ? VPC-32'd4 : VPC, modulo 2^32.
  - EXL <= 1.
  - If !int_pend and ExcCodeIn is 4 or 5: BadVAddr <= BadVAddrIn.
- mtc0 (en & !Req): writable fields are SR.IM, SR.EXL, SR.IE, EPC (all 32 bits), Count and Compare.
  - Writes to Cause, PRId, BadVAddr and unmapped indices are ignored.
  - The new value is visible on CP0Out the cycle after the write; there is no write-through bypass.
- Same-cycle priority for EXL: reset > Req > mtc0 > EXLClr. Example: en writing EXL=1 together with EXLClr leaves EXL=1.
- When Req = 1, any mtc0 in that cycle is discarded, because that instruction is flushed.
- EPCOut = EPC register. A mtc0 to EPC followed by eret in the next cycle sees the new value.

Optional Feature:
Macro: CP0_TIMER_EN.

Defined:
- Count increments by 1 every cycle with wrap 32'hFFFF_FFFF -> 0.
- A mtc0 to Count loads CP0In instead of incrementing that cycle.
- When Count == Compare at a posedge, TI <= 1. TI is sticky.
- A mtc0 to Compare loads CP0In and clears TI in the same cycle; the clear wins over a same-cycle match.
- TI is ORed into interrupt line TIMER_LINE.

Undefined:
- Count, Compare and TI are absent; indices 9 and 11 read 0 and writes to them are ignored.
- Cause[30] reads 0.

Test Plan:
1. Reset, then write SR=32'h0000_0401, then assert HWInt[0]=1 with VPC=32'h0000_3010, BDIn=0 -> Req=1 the same cycle. Next cycle: Cause.ExcCode=0, EPC=32'h0000_3010, EXL=1, Req=0.
2. ExcCodeIn=4, BDIn=1, VPC=32'h0000_3008, BadVAddrIn=32'h0000_0003, IE=0 -> Req=1. Then EPC=32'h0000_3004, BD=1, ExcCode=4, BadVAddr=32'h0000_0003.
3. Interrupt and ExcCodeIn=10 in the same cycle -> ExcCode=0 recorded, BadVAddr unchanged. Follow with EXLClr=1 -> EXL=0 next cycle and Req re-asserts while HWInt is still high.
4. mtc0 EPC=32'h0000_4000 in the same cycle as Req -> EPC=VPC, not 32'h0000_4000. mtc0 to Cause=32'hFFFF_FFFF -> Cause unchanged. Read index 15 -> PRID.
5. HW_INT_W=2, drive HWInt=2'b11 with IM written as 6'b111111 -> SR reads back IM=6'b000011 and IP[15:12]=0.
6. With CP0_TIMER_EN: SR=32'h0000_8001 (IM bit 5), Count=0, Compare=5 -> TI=1 after the Count==5 edge, Req=1. mtc0 Compare=100 -> TI=0 next cycle. Count=32'hFFFF_FFFF wraps to 0.
